msa_scheduler: RTL
==================

# msa_scheduler

Front end of the SHA-256 datapath. It accepts one 512-bit chunk as sixteen 32-bit big-endian message words on a valid/ready stream and expands it into the full 64-word message schedule W[0..63]. It then presents the schedule as a single 64×32 bundle on a valid/ready handshake to the compressor's `w` input. Padding and context management are done upstream; this block only buffers and expands.

## Interface
- No parameters. Sizes come from `sha256_pkg` constants.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `m_vld`  in  1  — message word valid.
- `m_rdy`  out  1  — message word ready; reset 0.
- `m_word`  in  32  — message word, big-endian; first word accepted = W[0].
- `m_last`  in  1  — chunk is the final chunk of the message; sampled only with the 16th word.
- `w_vld`  out  1  — schedule valid; reset 0.
- `w_rdy`  in  1  — downstream accepts the schedule.
- `w`  out  64×32 (packed `[63:0][31:0]`)  — `w[i]` = W[i]; reset all-zero.
- `w_last`  out  1  — copy of `m_last` for this chunk; reset 0.

## Operation
- The state machine is one-hot or encoded; the choice is free. States:
  - **IDLE**: entered on reset. Always moves to FILL on the next cycle.
  - **FILL**: `m_rdy`=1. Each `m_vld & m_rdy` writes `m_word` to `w[wcnt]` and increments the 6-bit `wcnt`. On the transfer where `wcnt`==15:
    - latch `m_last` into `w_last`;
    - clear `wcnt`;
    - go to EXPAND.
  - **EXPAND**: `m_rdy`=0. Each cycle, with t = `wcnt`, compute `w[16+t]` = σ1(`w[14+t]`) + `w[9+t]` + σ0(`w[1+t]`) + `w[t]`, mod 2^32.
    - σ0(x) = rotr7 ^ rotr18 ^ shr3.
    - σ1(x) = rotr17 ^ rotr19 ^ shr10.
    - After t=47, clear `wcnt` and go to OUTPUT.
  - **OUTPUT**: `w_vld`=1. `w` and `w_last` are held stable.
    - On `w_vld & w_rdy`: go to FILL and drop `w_vld` on the next cycle.
    - While `w_rdy`=0, hold indefinitely.
- `m_last` on words 0–14 is ignored.
- `m_word` is ignored whenever `m_rdy`=0.
- No overlap: the next chunk is not accepted until the current schedule is handed off. `w[0..15]` are overwritten by the next FILL, and `w[16..63]` by the next EXPAND.
- Reset asserted at any point, mid-FILL or mid-EXPAND included:
  - all outputs return to their reset values immediately;
  - the partial chunk is discarded;
  - after `rst_n` releases, operation restarts in IDLE.

## Timing
- `m_rdy` and `w_vld` are decoded directly from registered state. They are never combinational on `m_vld` or `w_rdy`.
- FILL takes a minimum of 16 cycles (back-to-back `m_vld`). Bubbles stretch FILL and do not change `wcnt`.
- Last word accepted at edge N:
  - EXPAND occupies cycles N+1 … N+48;
  - `w_vld` rises at edge N+49.
- Handshake accepted at edge M: `m_rdy` is 1 from edge M+1.
- Minimum period per chunk is 66 cycles: 16 FILL + 48 EXPAND + 1 OUTPUT + 1 FILL turnaround overlap.
- First `m_rdy` after reset release is at the second rising edge (IDLE→FILL).

## Structure
- Add to `sha256_pkg`:
  - `WORDS_IN_CHUNK` = 16;
  - `SCHED_LEN` = 64;
  - functions `smallSigma0(x)` and `smallSigma1(x)`, built on the existing `rightRotate32`;
  - state enum `MsaSchedulerState` {IDLE, FILL, EXPAND, OUTPUT}.
- No sub-module. The single expansion datapath is inline, with one adder chain per cycle indexed by `wcnt`.

## Test plan
- **"abc" chunk.** Input W0=0x61626380, W1..W14=0, W15=0x00000018, `m_last`=1 on word 15.
  - Expect W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - Expect W0..W15 unchanged, `w_last`=1.
  - Expect `w_vld` exactly 49 cycles after the last word.
- **Backpressure.** Hold `w_rdy`=0 for 20 cycles in OUTPUT.
  - `w`, `w_last` and `w_vld`=1 stay stable, and `m_rdy`=0 throughout.
  - Raise `w_rdy` for one cycle: `w_vld` drops and `m_rdy` rises next cycle.
- **Input bubbles.** Toggle `m_vld` randomly across 16 words; the schedule matches the golden model. Assert `m_last`=1 on word 3 and 0 on word 15: `w_last`=0.
- **Back-to-back chunks.** Stream two chunks with `w_rdy` tied to 1; both schedules match the model, and no words of chunk 2 are accepted before `w_vld` of chunk 1 completes.
- **Reset mid-EXPAND.** Deassert `rst_n` at t=20 of EXPAND: `w_vld`=0, `m_rdy`=0, `w`=0 immediately. After release, a fresh "abc" chunk produces correct results.
- **Random regression.** Run 1000 random chunks against the C/SystemVerilog reference model, with random `w_rdy` and `m_vld` gaps.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and bit-mixing helpers used across the datapath.
package sha256_pkg;

  localparam int unsigned WORDS_IN_CHUNK = 16;
  localparam int unsigned SCHED_LEN      = 64;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EXPAND,
    OUTPUT
  } MsaSchedulerState;

  function automatic logic [31:0] rightRotate32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rightRotate32(x, 5'd7) ^ rightRotate32(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rightRotate32(x, 5'd17) ^ rightRotate32(x, 5'd19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rightRotate32(x, 5'd2) ^ rightRotate32(x, 5'd13) ^ rightRotate32(x, 5'd22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rightRotate32(x, 5'd6) ^ rightRotate32(x, 5'd11) ^ rightRotate32(x, 5'd25);
  endfunction

  function automatic logic [31:0] choose32(input logic [31:0] e, input logic [31:0] f,
                                           input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority32(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/msa_scheduler.sv
// SHA-256 message schedule front end: buffers 16 input words, expands them in place to
// W[0..63] one word per cycle, then hands the whole schedule to the compressor.
module msa_scheduler
  import sha256_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             m_vld,
  output logic                             m_rdy,
  input  logic [WORD_W-1:0]                m_word,
  input  logic                             m_last,
  output logic                             w_vld,
  input  logic                             w_rdy,
  output logic [SCHED_LEN-1:0][WORD_W-1:0] w,
  output logic                             w_last
);

  localparam logic [5:0] LastFillIdx   = 6'(WORDS_IN_CHUNK - 1);
  localparam logic [5:0] LastExpandIdx = 6'(SCHED_LEN - WORDS_IN_CHUNK - 1);

  MsaSchedulerState                  state_q;
  logic [5:0]                        wcnt_q;
  logic [SCHED_LEN-1:0][WORD_W-1:0]  w_q;
  logic                              w_last_q;
  logic                              m_rdy_q;
  logic                              w_vld_q;

  logic [5:0]        idx_new;
  logic [5:0]        idx_s1;
  logic [5:0]        idx_w9;
  logic [5:0]        idx_s0;
  logic [WORD_W-1:0] exp_word;

  // One adder chain, indexed by wcnt: produces W[16+t] from the window starting at W[t].
  always_comb begin
    idx_new  = wcnt_q + 6'd16;
    idx_s1   = wcnt_q + 6'd14;
    idx_w9   = wcnt_q + 6'd9;
    idx_s0   = wcnt_q + 6'd1;
    exp_word = smallSigma1(w_q[idx_s1]) + w_q[idx_w9] + smallSigma0(w_q[idx_s0]) + w_q[wcnt_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      w_q      <= '0;
      w_last_q <= 1'b0;
      m_rdy_q  <= 1'b0;
      w_vld_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= FILL;
          m_rdy_q <= 1'b1;
        end
        FILL: begin
          if (m_vld && m_rdy_q) begin
            w_q[wcnt_q] <= m_word;
            if (wcnt_q == LastFillIdx) begin
              w_last_q <= m_last;
              wcnt_q   <= '0;
              m_rdy_q  <= 1'b0;
              state_q  <= EXPAND;
            end else begin
              wcnt_q <= wcnt_q + 6'd1;
            end
          end
        end
        EXPAND: begin
          w_q[idx_new] <= exp_word;
          if (wcnt_q == LastExpandIdx) begin
            wcnt_q  <= '0;
            state_q <= OUTPUT;
          end else begin
            wcnt_q <= wcnt_q + 6'd1;
          end
        end
        OUTPUT: begin
          // w_vld is registered, so it rises the cycle after OUTPUT is entered.
          if (w_vld_q && w_rdy) begin
            w_vld_q <= 1'b0;
            m_rdy_q <= 1'b1;
            state_q <= FILL;
          end else begin
            w_vld_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_rdy  = m_rdy_q;
  assign w_vld  = w_vld_q;
  assign w      = w_q;
  assign w_last = w_last_q;

endmodule
